riscv_membuf_ot: RTL and testbench
==================================

# riscv_membuf_ot

Parametrised memory access buffer with outstanding-transaction tracking. It sits between the CPU load/store path and the BIU.
- Queues CPU requests in a DEPTH-entry FIFO.
- Issues them to memory while at most MAX_PENDING remain unacknowledged.
- On a flush, silently absorbs acknowledges belonging to cancelled requests, so only live responses reach the CPU.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2
- DBITS, 32, request payload width
- MAX_PENDING, 2, maximum issued-but-unacknowledged requests; ≥1
- CW, $clog2(MAX_PENDING+1), counter width (derived, not overridable)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  flush: drop queued requests, convert pending to discard
- ena_i  in  1  stall control; low freezes queue and issue
- req_i  in  1  CPU request valid
- d_i  in  DBITS  CPU request payload
- req_o  out  1  request to memory
- q_o  out  DBITS  payload to memory, valid with req_o
- ack_i  in  1  memory acknowledge, one per issued request, in order
- ack_o  out  1  forwarded acknowledge for a live (non-discarded) request
- empty_o  out  1  queue empty
- full_o  out  1  queue full
- pending_o  out  CW  live outstanding count
- ovf_o  out  1  pulse: req_i dropped because queue full

## Operation
- State:
  - FIFO: rd/wr pointers with one extra wrap bit.
  - pend counter, CW bits.
  - disc counter, CW bits.
  - Invariant: pend+disc ≤ MAX_PENDING.
- Credit: issue allowed when pend+disc < MAX_PENDING, or when ack_i is high in the same cycle (freed slot reused immediately).
- Issue: req_o = ena_i & ~clr_i & credit & (~empty_o | bypass).
  - bypass is defined in Configuration; bypass = 0 when the macro is absent.
  - Queue head is popped on issue when ~empty_o.
  - q_o = queue head; with bypass active, q_o = d_i.
- Push: req_i & ena_i & ~clr_i, and the request is not bypassed → write d_i at the tail.
  - If full_o and there is no same-cycle pop: request dropped, ovf_o = 1.
  - Push and pop in the same cycle on a full queue is legal.
- Counters, with ena_i high or low:
  - ack_i with disc≠0 → disc−1; ack_o = 0.
  - ack_i with disc=0, pend≠0 → pend−1; ack_o = 1.
  - ack_i with both counters zero → ignored (spurious); ack_o = 0; counters saturate at 0.
  - Issue → pend+1, in the same cycle as any decrement.
- clr_i (synchronous, priority over ena_i):
  - Pointers reset.
  - disc ← disc+pend−(ack_i?1:0).
  - pend ← 0.
  - No issue, no push.
- ena_i low: no push, no pop, req_o = 0; acks still counted and forwarded (the memory side cannot stall).

## Timing
- Reset values: req_o 0, ack_o 0, empty_o 1, full_o 0, pending_o 0, ovf_o 0, q_o 0 (macro off) / d_i (macro on); disc 0.
- Reset mid-transaction clears all counters; late acks after reset are treated as spurious and ignored.
- req_o, q_o, ack_o and ovf_o are combinational from inputs and state; empty_o, full_o and pending_o are registered state.
- Latency req_i→req_o: 0 cycles with bypass and an empty queue with credit; otherwise ≥1 cycle.
- ack_i→ack_o: 0 cycles.
- Ordering: requests leave in CPU order; bypass never overtakes queued entries.
- pend wraps never; MAX_PENDING is unreachable+1 by construction.

## Configuration
- RV_MEMBUF_BYPASS_EN defined:
  - bypass = empty_o & req_i.
  - An empty queue forwards d_i combinationally to q_o/req_o in the same cycle; the entry is not written.
- RV_MEMBUF_BYPASS_EN undefined:
  - Every request is written to the queue first.
  - req_o asserts no earlier than the cycle after req_i; q_o is always the queue head.

## Test plan
- Reset, then idle → all outputs at reset values; a single ack_i → ack_o=0, pending_o stays 0.
- MAX_PENDING=2, DEPTH=4, four back-to-back req_i (d=0xA0..A3), no ack:
  - Two issues, pending_o=2, queue holds A2,A3, req_o low.
  - One ack_i → ack_o=1, A2 issued in the same cycle.
- Two issued, clr_i pulse, then three ack_i with one new req_i(0xB0) issued after the flush:
  - First two acks → ack_o=0.
  - Third ack → ack_o=1; pending_o returns to 0.
- Queue full (4 entries), no credit, req_i=1 → ovf_o=1, contents unchanged; the same with a concurrent pop → accepted, ovf_o=0.
- ena_i low for 3 cycles with req_i=1 and ack_i pulses → no push, req_o=0, ack_o forwarded, pending_o decrements.
- Macro on vs off, empty queue, req_i=0x55:
  - On: req_o and q_o=0x55 in the same cycle.
  - Off: req_o in the next cycle with q_o=0x55.

Source files
------------

// File: rtl/riscv_membuf_ot.sv
// Memory access buffer: DEPTH-entry request FIFO with outstanding-ack tracking and flush-time ack discard.
// Optional same-cycle forwarding on an empty queue is enabled by defining RV_MEMBUF_BYPASS_EN.
module riscv_membuf_ot #(
  parameter int DEPTH       = 4,
  parameter int DBITS       = 32,
  parameter int MAX_PENDING = 2,
  localparam int CW         = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic             req_i,
  input  logic [DBITS-1:0] d_i,
  output logic             req_o,
  output logic [DBITS-1:0] q_o,
  input  logic             ack_i,
  output logic             ack_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    pending_o,
  output logic             ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] MAX_P = (CW + 1)'(MAX_PENDING);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pend_q, pend_d, disc_q, disc_d;

  logic [CW:0]      inflight;
  logic [DBITS-1:0] head;
  logic             credit, bypass, issue, pop, push_req, push;
  logic             ack_disc, ack_live;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pending_o = pend_q;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // An ack in the same cycle frees a slot that the next issue may take immediately.
  assign inflight = {1'b0, pend_q} + {1'b0, disc_q};
  assign credit   = (inflight < MAX_P) | ack_i;

`ifdef RV_MEMBUF_BYPASS_EN
  assign bypass = empty_o & req_i;
  assign q_o    = empty_o ? d_i : head;
`else
  assign bypass = 1'b0;
  assign q_o    = empty_o ? '0 : head;
`endif

  assign issue    = ena_i & ~clr_i & credit & (~empty_o | bypass);
  assign pop      = issue & ~empty_o;
  assign push_req = req_i & ena_i & ~clr_i & ~(bypass & issue);
  assign push     = push_req & (~full_o | pop);
  assign ovf_o    = push_req & full_o & ~pop;
  assign req_o    = issue;

  // Acks retire discarded requests first: they are older than any live one.
  assign ack_disc = ack_i & (disc_q != '0);
  assign ack_live = ack_i & (disc_q == '0) & (pend_q != '0);
  assign ack_o    = ack_live;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = pend_q;
    disc_d   = disc_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pend_d   = '0;
      disc_d   = CW'(inflight - (CW + 1)'(ack_disc | ack_live));
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      disc_d = disc_q - CW'(ack_disc);
      pend_d = pend_q - CW'(ack_live) + CW'(issue);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      disc_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      disc_q   <= disc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= d_i;
  end

endmodule

// File: tb/tb_riscv_membuf_ot.sv
// Bench for riscv_membuf_ot: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue/counter model of the buffer.
module tb_riscv_membuf_ot;
  localparam int DEPTH = 4;
  localparam int DBITS = 32;
  localparam int MAXP  = 2;
  localparam int CW    = $clog2(MAXP + 1);
`ifdef RV_MEMBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0, ena = 1'b0, req = 1'b0, ack = 1'b0;
  logic [DBITS-1:0] d = '0;
  logic             req_o, ack_o, empty_o, full_o, ovf_o;
  logic [DBITS-1:0] q_o;
  logic [CW-1:0]    pending_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DBITS-1:0] mq[$];
  int m_pend = 0;
  int m_disc = 0;

  riscv_membuf_ot #(.DEPTH(DEPTH), .DBITS(DBITS), .MAX_PENDING(MAXP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .ena_i(ena), .req_i(req), .d_i(d),
    .req_o(req_o), .q_o(q_o), .ack_i(ack), .ack_o(ack_o), .empty_o(empty_o),
    .full_o(full_o), .pending_o(pending_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus: inputs change 1 time unit after the rising edge, checks follow 1 unit later.
  task automatic drive(input bit rst, input bit e, input bit c, input bit r, input bit a,
                       input logic [DBITS-1:0] dv);
    @(posedge clk);
    #1;
    rst_n = ~rst; ena = e; clr = c; req = r; ack = a; d = dv;
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mq.size() == 0 && m_pend + m_disc == 0) begin
        done = 1'b1;
        break;
      end
      drive(0, 1, 0, 0, (m_pend + m_disc) > 0, '0);
    end
    chk("drain_timeout", {63'b0, done}, 64'd1);
    drive(0, 1, 0, 0, 0, '0);
  endtask

  // Reference model: evaluated mid-cycle on the inputs of that cycle, then advanced to the next state.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_pend = 0;
      m_disc = 0;
    end else begin
      int   sum;
      bit   m_empty, m_full, credit, byp, iss, pushreq, pop, e_ack, e_ovf;
      logic [DBITS-1:0] e_q;
      sum     = m_pend + m_disc;
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == DEPTH);
      credit  = (sum < MAXP) || ack;
      byp     = BYP && m_empty && req;
      iss     = ena && !clr && credit && (!m_empty || byp);
      pop     = iss && !m_empty;
      pushreq = req && ena && !clr && !(byp && iss);
      e_ovf   = pushreq && m_full && !pop;
      e_ack   = ack && m_disc == 0 && m_pend != 0;
      e_q     = byp ? d : (m_empty ? '0 : mq[0]);

      chk("req_o", {63'b0, req_o}, {63'b0, iss});
      if (iss) chk("q_o", {32'b0, q_o}, {32'b0, e_q});
      chk("ack_o", {63'b0, ack_o}, {63'b0, e_ack});
      chk("ovf_o", {63'b0, ovf_o}, {63'b0, e_ovf});
      chk("empty_o", {63'b0, empty_o}, {63'b0, m_empty});
      chk("full_o", {63'b0, full_o}, {63'b0, m_full});
      chk("pending_o", 64'(pending_o), 64'(m_pend));

      if (clr) begin
        mq.delete();
        m_disc = sum - ((ack && sum > 0) ? 1 : 0);
        m_pend = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (pushreq && (!m_full || pop)) mq.push_back(d);
        if (ack && m_disc > 0) m_disc--;
        else if (ack && m_pend > 0) m_pend--;
        if (iss) m_pend++;
      end
      chk("invariant", {63'b0, (m_pend + m_disc) <= MAXP}, 64'd1);
    end
  end

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_req_o", {63'b0, req_o}, 64'd0);
    chk("rst_ack_o", {63'b0, ack_o}, 64'd0);
    chk("rst_empty_o", {63'b0, empty_o}, 64'd1);
    chk("rst_full_o", {63'b0, full_o}, 64'd0);
    chk("rst_pending_o", 64'(pending_o), 64'd0);
    chk("rst_ovf_o", {63'b0, ovf_o}, 64'd0);
    chk("rst_q_o", {32'b0, q_o}, BYP ? {32'b0, d} : 64'd0);

    drive(0, 1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 1, '0);
    chk("spurious_ack_o", {63'b0, ack_o}, 64'd0);
    drive(0, 1, 0, 0, 0, '0);
    chk("spurious_pending", 64'(pending_o), 64'd0);

    // Four back-to-back requests, credit for two
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, 32'hA0 + 32'(i));
    drive(0, 1, 0, 0, 0, '0);
    chk("bb_pending", 64'(pending_o), 64'd2);
    chk("bb_req_o", {63'b0, req_o}, 64'd0);
    chk("bb_head", {32'b0, q_o}, 64'hA2);
    chk("bb_empty", {63'b0, empty_o}, 64'd0);
    drive(0, 1, 0, 0, 1, '0);
    chk("bb_ack_o", {63'b0, ack_o}, 64'd1);
    chk("bb_reissue", {63'b0, req_o}, 64'd1);
    chk("bb_reissue_q", {32'b0, q_o}, 64'hA2);
    drive(0, 1, 0, 0, 0, '0);
    chk("bb_pending2", 64'(pending_o), 64'd2);
    chk("bb_head2", {32'b0, q_o}, 64'hA3);
    drain();

    // Flush with two outstanding, then one fresh request
    drive(0, 1, 0, 1, 0, 32'hD0);
    drive(0, 1, 0, 1, 0, 32'hD1);
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 1, 0, 0, 0, '0);
    chk("fl_pending", 64'(pending_o), 64'd2);
    drive(0, 1, 1, 0, 0, '0);
    chk("fl_req_o", {63'b0, req_o}, 64'd0);
    drive(0, 1, 0, 1, 1, 32'hB0);
    chk("fl_ack1", {63'b0, ack_o}, 64'd0);
    chk("fl_pending0", 64'(pending_o), 64'd0);
    drive(0, 1, 0, 0, 1, '0);
    chk("fl_ack2", {63'b0, ack_o}, 64'd0);
    drive(0, 1, 0, 0, 0, '0);
    chk("fl_pending1", 64'(pending_o), 64'd1);
    drive(0, 1, 0, 0, 1, '0);
    chk("fl_ack3", {63'b0, ack_o}, 64'd1);
    drive(0, 1, 0, 0, 0, '0);
    chk("fl_pending_end", 64'(pending_o), 64'd0);
    chk("fl_empty_end", {63'b0, empty_o}, 64'd1);

    // Full queue with no credit, then with a concurrent pop
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 1, 0, 32'hE0 + 32'(i));
    drive(0, 1, 0, 1, 0, 32'hF0);
    chk("ovf_full", {63'b0, full_o}, 64'd1);
    chk("ovf_o", {63'b0, ovf_o}, 64'd1);
    chk("ovf_req_o", {63'b0, req_o}, 64'd0);
    drive(0, 1, 0, 1, 1, 32'hF1);
    chk("pp_ovf_o", {63'b0, ovf_o}, 64'd0);
    chk("pp_req_o", {63'b0, req_o}, 64'd1);
    chk("pp_q_o", {32'b0, q_o}, 64'hE2);
    chk("pp_ack_o", {63'b0, ack_o}, 64'd1);

    // Stalled: no push or issue, acks still counted
    drive(0, 0, 0, 1, 1, 32'h60);
    chk("st_req_o", {63'b0, req_o}, 64'd0);
    chk("st_ack_o", {63'b0, ack_o}, 64'd1);
    chk("st_ovf_o", {63'b0, ovf_o}, 64'd0);
    chk("st_full", {63'b0, full_o}, 64'd1);
    drive(0, 0, 0, 1, 0, 32'h61);
    chk("st_pending1", 64'(pending_o), 64'd1);
    chk("st_req_o2", {63'b0, req_o}, 64'd0);
    drive(0, 0, 0, 1, 1, 32'h62);
    chk("st_ack_o2", {63'b0, ack_o}, 64'd1);
    drive(0, 0, 0, 0, 0, '0);
    chk("st_pending0", 64'(pending_o), 64'd0);
    chk("st_head", {32'b0, q_o}, 64'hE3);
    drain();

    // Empty-queue latency
    drive(0, 1, 0, 1, 0, 32'h55);
    if (BYP) begin
      chk("byp_req_o", {63'b0, req_o}, 64'd1);
      chk("byp_q_o", {32'b0, q_o}, 64'h55);
    end else begin
      chk("nobyp_req_o0", {63'b0, req_o}, 64'd0);
      drive(0, 1, 0, 0, 0, '0);
      chk("nobyp_req_o1", {63'b0, req_o}, 64'd1);
      chk("nobyp_q_o", {32'b0, q_o}, 64'h55);
    end
    drain();

    // Randomized traffic with occasional flushes, stalls, spurious acks and resets
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_ena, r_clr, r_req, r_ack;
      r_rst = ($urandom % 400) == 0;
      r_ena = ($urandom % 8) != 0;
      r_clr = ($urandom % 25) == 0;
      r_req = ($urandom % 3) != 0;
      r_ack = (m_pend + m_disc > 0) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      drive(r_rst, r_ena, r_clr, r_req, r_ack, $urandom);
    end
    drive(0, 1, 0, 0, 0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
